// File: rtl/led_sequencer.sv
// -----------------------------------------------------------------------------
// led_sequencer
//
// Purpose:
//   Four-LED pattern sequencer with a debounced mode button. A press walks the
//   mode OFF -> BLINK -> CHASE -> BOUNCE -> OFF. A prescaler divides clk into
//   pattern steps; every step advances the current mode's LED pattern.
//
// Optional feature:
//   LED_SEQUENCER_PWM_EN - when defined, adds the bright[3:0] input and a
//   free-running 4-bit PWM counter that dims every LED (duty = bright/16).
//   When undefined, led is the pattern register directly.
//
// Parameters:
//   TICK_DIV   clk cycles per pattern step (>= 2)
//   DB_CYCLES  consecutive stable cycles needed to accept a button level (>= 2)
//
// Ports:
//   clk      single clock, rising edge
//   rst_n    asynchronous active-low reset
//   btn_n    raw asynchronous active-low mode button
//   en       run enable; 0 freezes the prescaler and pattern stepping
//   bright   (PWM build only) brightness 0..15
//   led      LED drive, bit0 is the lowest LED
//   mode     current mode: 0 OFF, 1 BLINK, 2 CHASE, 3 BOUNCE
//   tick     one-cycle pulse on each accepted pattern step
// -----------------------------------------------------------------------------
module led_sequencer #(
    parameter int TICK_DIV  = 12_500_000,
    parameter int DB_CYCLES = 250_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_n,
    input  logic       en,
`ifdef LED_SEQUENCER_PWM_EN
    input  logic [3:0] bright,
`endif
    output logic [3:0] led,
    output logic [1:0] mode,
    output logic       tick
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DB_CYCLES);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_MAX    = DW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_t;

    // ------------------------------------------------------------------
    // Button synchronizer and debouncer
    // ------------------------------------------------------------------
    logic          sync1_reg;
    logic          sync2_reg;
    logic          db_level_reg;
    logic [DW-1:0] db_cnt_reg;
    logic          press_reg;

    // press_reg is raised on the same edge that the debounced level falls,
    // so it is high for exactly the first cycle of the new low level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg    <= 1'b1;
            sync2_reg    <= 1'b1;
            db_level_reg <= 1'b1;
            db_cnt_reg   <= '0;
            press_reg    <= 1'b0;
        end else begin
            sync1_reg <= btn_n;
            sync2_reg <= sync1_reg;
            press_reg <= 1'b0;
            if (sync2_reg != db_level_reg) begin
                if (db_cnt_reg == DB_MAX) begin
                    db_level_reg <= sync2_reg;
                    db_cnt_reg   <= '0;
                    press_reg    <= ~sync2_reg;
                end else begin
                    db_cnt_reg <= db_cnt_reg + 1'b1;
                end
            end else begin
                // Any return to the accepted level restarts the qualification.
                db_cnt_reg <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Mode FSM, prescaler and pattern stepping
    // ------------------------------------------------------------------
    mode_t         state_reg,   state_next;
    logic [3:0]    pattern_reg, pattern_next;
    logic          dir_up_reg,  dir_up_next;
    logic [PW-1:0] presc_reg,   presc_next;
    logic          step_due;

    assign step_due = en && (presc_reg == PRESC_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= MODE_OFF;
            pattern_reg <= 4'b0000;
            dir_up_reg  <= 1'b1;
            presc_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            pattern_reg <= pattern_next;
            dir_up_reg  <= dir_up_next;
            presc_reg   <= presc_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pattern_next = pattern_reg;
        dir_up_next  = dir_up_reg;
        presc_next   = presc_reg;
        tick         = 1'b0;

        if (press_reg) begin
            // A press outranks a coincident step: the step is dropped and
            // tick is withheld, and everything restarts from the entry state.
            case (state_reg)
                MODE_OFF:    state_next = MODE_BLINK;
                MODE_BLINK:  state_next = MODE_CHASE;
                MODE_CHASE:  state_next = MODE_BOUNCE;
                default:     state_next = MODE_OFF;
            endcase
            presc_next  = '0;
            dir_up_next = 1'b1;
            case (state_next)
                MODE_CHASE, MODE_BOUNCE: pattern_next = 4'b0001;
                default:                 pattern_next = 4'b0000;
            endcase
        end else if (step_due) begin
            tick       = 1'b1;
            presc_next = '0;
            case (state_reg)
                MODE_OFF:   pattern_next = 4'b0000;
                MODE_BLINK: pattern_next = ~pattern_reg;
                MODE_CHASE: pattern_next = {pattern_reg[2:0], pattern_reg[3]};
                default: begin
                    // Reverse at the ends without revisiting the end LED.
                    if (dir_up_reg) begin
                        if (pattern_reg[3]) begin
                            pattern_next = 4'b0100;
                            dir_up_next  = 1'b0;
                        end else begin
                            pattern_next = {pattern_reg[2:0], 1'b0};
                        end
                    end else begin
                        if (pattern_reg[0]) begin
                            pattern_next = 4'b0010;
                            dir_up_next  = 1'b1;
                        end else begin
                            pattern_next = {1'b0, pattern_reg[3:1]};
                        end
                    end
                end
            endcase
        end else if (en) begin
            presc_next = presc_reg + 1'b1;
        end
    end

    assign mode = state_reg;

    // ------------------------------------------------------------------
    // LED output stage
    // ------------------------------------------------------------------
`ifdef LED_SEQUENCER_PWM_EN
    logic [3:0] pwm_cnt_reg;
    logic       pwm_on;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_reg <= 4'd0;
        end else begin
            pwm_cnt_reg <= pwm_cnt_reg + 4'd1;
        end
    end

    // bright=0 never lights; bright=15 lights 15 of every 16 cycles.
    assign pwm_on = (pwm_cnt_reg < bright);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_led_pwm
            assign led[gi] = pattern_reg[gi] & pwm_on;
        end
    endgenerate
`else
    assign led = pattern_reg;
`endif

endmodule

// File: tb/tb_led_sequencer.sv
// -----------------------------------------------------------------------------
// tb_led_sequencer
//
// Purpose:
//   Self-checking bench for led_sequencer with TICK_DIV=4, DB_CYCLES=3.
//   Stimulus pushes hand-computed expectations (cycle, mode, led, tick) into a
//   scoreboard queue; a monitor on the falling edge pops every entry due in
//   that cycle and compares it with the DUT outputs.
//   Cycle numbers used below are relative to reset release ("a").
// -----------------------------------------------------------------------------
module tb_led_sequencer;

    logic       clk;
    logic       rst_n;
    logic       btn_n;
    logic       en;
    logic [3:0] led;
    logic [1:0] mode;
    logic       tick;

    int cyc    = 0;
    int base   = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [1:0] mode;
        logic [3:0] led;
        logic       tick;
        string      name;
    } exp_t;

    exp_t sb_q[$];

    led_sequencer #(
        .TICK_DIV (4),
        .DB_CYCLES(3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .btn_n(btn_n),
        .en   (en),
        .led  (led),
        .mode (mode),
        .tick (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change 1 time unit after the rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int a);
        while ((cyc - base) < a) cycle();
    endtask

    task automatic expect_at(input int a, input logic [1:0] m, input logic [3:0] l,
                             input logic t, input string n);
        exp_t e;
        e.cyc  = base + a;
        e.mode = m;
        e.led  = l;
        e.tick = t;
        e.name = n;
        sb_q.push_back(e);
    endtask

    // Button held low 6 cycles then released for 7: press pulse at s+5,
    // new mode visible at s+6.
    task automatic press(input int s);
        wait_until(s);
        btn_n = 1'b0;
        wait_until(s + 6);
        btn_n = 1'b1;
        wait_until(s + 13);
    endtask

    // Monitor: compare every scoreboard entry due in this cycle.
    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].cyc <= cyc) begin
                checks++;
                if (sb_q[i].cyc < cyc || mode !== sb_q[i].mode ||
                    led !== sb_q[i].led || tick !== sb_q[i].tick) begin
                    errors++;
                    $display("FAIL %s cyc=%0d: got mode=%0d led=%b tick=%b, want mode=%0d led=%b tick=%b (due cyc %0d)",
                             sb_q[i].name, cyc - base, mode, led, tick,
                             sb_q[i].mode, sb_q[i].led, sb_q[i].tick, sb_q[i].cyc - base);
                end else begin
                    $display("check %s cyc=%0d mode=%0d led=%b tick=%b ok",
                             sb_q[i].name, cyc - base, mode, led, tick);
                end
                sb_q.delete(i);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        btn_n = 1'b1;
        cycle();
        cycle();
        checks++;
        if (mode !== 2'd0 || led !== 4'b0000 || tick !== 1'b0) begin
            errors++;
            $display("FAIL direct_reset: got mode=%0d led=%b tick=%b, want mode=0 led=0000 tick=0",
                     mode, led, tick);
        end else begin
            $display("check direct_reset mode=%0d led=%b tick=%b ok", mode, led, tick);
        end
        expect_at(cyc, 2'd0, 4'b0000, 1'b0, "reset_state");
        cycle();
        rst_n = 1'b1;
        en    = 1'b1;
        base  = cyc;

        // Idle OFF: tick every 4th cycle, led dark.
        for (int k = 0; k < 8; k++)
            expect_at(k, 2'd0, 4'b0000, (k % 4 == 3), $sformatf("idle_%0d", k));

        // Clean press held 10 cycles: pulse at a=13, BLINK at a=14.
        expect_at(12, 2'd0, 4'b0000, 1'b0, "pre_press");
        expect_at(13, 2'd0, 4'b0000, 1'b0, "press_cycle");
        expect_at(14, 2'd1, 4'b0000, 1'b0, "mode_blink");
        expect_at(17, 2'd1, 4'b0000, 1'b1, "blink_tick");
        expect_at(18, 2'd1, 4'b1111, 1'b0, "blink_on");
        wait_until(8);
        btn_n = 1'b0;
        wait_until(18);
        btn_n = 1'b1;
        wait_until(24);

        // Two-cycle glitch: must not change mode.
        expect_at(30, 2'd1, 4'b0000, 1'b0, "glitch_hold");
        expect_at(33, 2'd1, 4'b0000, 1'b1, "glitch_hold_tick");
        expect_at(34, 2'd1, 4'b1111, 1'b0, "glitch_blink_on");
        btn_n = 1'b0;
        wait_until(26);
        btn_n = 1'b1;
        wait_until(36);

        // Five presses: 1->2->3->0 (wrap)->1->2.
        expect_at(41, 2'd1, 4'b0000, 1'b0, "press_tick_blink");
        expect_at(42, 2'd2, 4'b0001, 1'b0, "mode_chase");
        expect_at(54, 2'd2, 4'b1000, 1'b0, "chase_before");
        expect_at(55, 2'd3, 4'b0001, 1'b0, "mode_bounce");
        expect_at(67, 2'd3, 4'b1000, 1'b0, "bounce_before");
        expect_at(68, 2'd0, 4'b0000, 1'b0, "wrap_off");
        expect_at(80, 2'd0, 4'b0000, 1'b0, "off_before");
        expect_at(81, 2'd1, 4'b0000, 1'b0, "wrap_blink");
        expect_at(93, 2'd1, 4'b1111, 1'b0, "blink_before");
        expect_at(94, 2'd2, 4'b0001, 1'b0, "chase_again");
        press(36);
        press(49);
        press(62);
        press(75);
        press(88);

        // en=0 for 20 cycles in CHASE at 0100 with prescaler at its last count.
        expect_at(102, 2'd2, 4'b0100, 1'b0, "chase_0100");
        expect_at(105, 2'd2, 4'b0100, 1'b0, "freeze_tick_gated");
        expect_at(115, 2'd2, 4'b0100, 1'b0, "frozen_mid");
        expect_at(124, 2'd2, 4'b0100, 1'b0, "frozen_end");
        expect_at(125, 2'd2, 4'b0100, 1'b1, "resume_tick");
        expect_at(126, 2'd2, 4'b1000, 1'b0, "resume_step");
        wait_until(105);
        en = 1'b0;
        wait_until(125);
        en = 1'b1;

        // Press pulse at a=133 coincides with a CHASE tick.
        expect_at(130, 2'd2, 4'b0001, 1'b0, "chase_wrap");
        expect_at(133, 2'd2, 4'b0001, 1'b0, "press_vs_tick");
        expect_at(134, 2'd3, 4'b0001, 1'b0, "press_wins");
        expect_at(137, 2'd3, 4'b0001, 1'b1, "bounce_first_tick");
        begin
            logic [3:0] bounce_seq [8];
            bounce_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                           4'b0010, 4'b0001, 4'b0010, 4'b0100};
            for (int i = 0; i < 8; i++)
                expect_at(138 + 4 * i, 2'd3, bounce_seq[i], 1'b0, $sformatf("bounce_%0d", i));
        end
        press(128);

        // Asynchronous reset mid-BOUNCE (led 0100 at a=166).
        expect_at(167, 2'd0, 4'b0000, 1'b0, "async_reset");
        expect_at(168, 2'd0, 4'b0000, 1'b0, "in_reset");
        expect_at(172, 2'd0, 4'b0000, 1'b0, "post_reset");
        expect_at(173, 2'd0, 4'b0000, 1'b1, "post_reset_tick");
        wait_until(167);
        rst_n = 1'b0;
        wait_until(168);
        checks++;
        if (mode !== 2'd0 || led !== 4'b0000 || tick !== 1'b0) begin
            errors++;
            $display("FAIL direct_async_reset: got mode=%0d led=%b tick=%b, want mode=0 led=0000 tick=0",
                     mode, led, tick);
        end else begin
            $display("check direct_async_reset mode=%0d led=%b tick=%b ok", mode, led, tick);
        end
        wait_until(170);
        rst_n = 1'b1;
        wait_until(180);

        while (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got never compared, want compared at cyc %0d",
                     sb_q[0].name, sb_q[0].cyc - base);
            sb_q.delete(0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 12_500_000: clk cycles per pattern step; legal range >= 2.
REQ-002 The block SHALL have parameter DB_CYCLES, default 250_000: consecutive stable cycles required to accept a button level; legal range >= 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port btn_n, input, 1 bit: raw, asynchronous, active-low mode button.
REQ-006 The block SHALL have port en, input, 1 bit: run enable; 0 freezes pattern stepping.
REQ-007 The block SHALL have port led, output, 4 bits: registered LED drive; bit0 is the lowest LED.
REQ-008 The block SHALL have port mode, output, 2 bits: current mode (0 OFF, 1 BLINK, 2 CHASE, 3 BOUNCE).
REQ-009 The block SHALL have port tick, output, 1 bit: one-cycle pulse on each accepted pattern step.

Function
REQ-010 The block SHALL pass btn_n through a 2-flop synchronizer before any other use.
REQ-011 The debouncer SHALL update its debounced level only after the synchronized input differs from it for DB_CYCLES consecutive cycles; any bounce restarts the count.
REQ-012 A debounced 1->0 transition SHALL generate an internal press pulse exactly one cycle long; a release SHALL generate no pulse.
REQ-013 The prescaler SHALL count 0..TICK_DIV-1 while en=1, hold its value while en=0, and assert tick in the cycle it equals TICK_DIV-1 with en=1, then wrap to 0.
REQ-014 The mode FSM SHALL advance OFF->BLINK->CHASE->BOUNCE->OFF on each press pulse; mode SHALL update on the clock edge following the press pulse (1-cycle latency).
REQ-015 On a mode change, the prescaler, step state and BOUNCE direction SHALL clear, and led SHALL load the new mode's entry pattern on the same edge.
REQ-016 Entry patterns SHALL be: OFF 0000, BLINK 0000, CHASE 0001, BOUNCE 0001 (direction up).
REQ-017 In OFF, led SHALL stay 0000; ticks are counted but have no effect on led.
REQ-018 In BLINK, each tick SHALL toggle led between 0000 and 1111.
REQ-019 In CHASE, each tick SHALL rotate led left one-hot: 0001->0010->0100->1000->0001.
REQ-020 In BOUNCE, each tick SHALL shift the one-hot led in the current direction, reversing at 1000 and at 0001 (sequence 0001,0010,0100,1000,0100,0010,0001,...); no position is repeated at the ends.
REQ-021 led SHALL change on the edge at which tick is high (tick and the new pattern never appear in the same cycle; the pattern lags tick by one cycle).
REQ-022 If a press pulse and a tick coincide, the press SHALL win; the step SHALL be discarded and tick SHALL be suppressed in that cycle.
REQ-023 While en=0, led SHALL hold its value and tick SHALL stay 0; presses SHALL still change mode and load the entry pattern.

Reset
REQ-024 Asserting rst_n=0 SHALL immediately force mode=0, led=0000, tick=0, the prescaler to 0, the debounce counter to 0, the debounced level to 1 (released), both synchronizer flops to 1, and the direction to up, including mid-sequence.
REQ-025 After deassertion, the first press pulse SHALL be produced no earlier than 2+DB_CYCLES cycles after btn_n falls.

Configuration
REQ-026 When the macro LED_SEQUENCER_PWM_EN is defined, the block SHALL add an input bright[3:0] and a free-running 4-bit PWM counter reset to 0, and SHALL drive led = pattern AND (pwm_cnt < bright) per bit; bright=0 gives off and bright=15 gives a 15/16 duty cycle.
REQ-027 When LED_SEQUENCER_PWM_EN is not defined, the bright port and PWM counter SHALL be absent, and led SHALL equal the pattern register directly.

Verification (TICK_DIV=4, DB_CYCLES=3)
REQ-028 The bench SHALL check: reset then en=1 with no press -> mode=0, led=0000, and tick every 4th cycle.
REQ-029 The bench SHALL check: a clean btn_n press held for 10 cycles -> exactly one mode increment (0->1) and led=0000, followed by 1111 one cycle after the next tick.
REQ-030 The bench SHALL check: a btn_n glitch low for 2 cycles -> no mode change; 4 presses -> mode wraps 3->0.
REQ-031 The bench SHALL check: in BOUNCE over 8 ticks -> led sequence 0010,0100,1000,0100,0010,0001,0010,0100.
REQ-032 The bench SHALL check: a press pulse coincident with a tick in CHASE -> no tick pulse, mode=3, led=0001.
REQ-033 The bench SHALL check: en=0 for 20 cycles in CHASE at led=0100 -> led held, tick=0, and the prescaler resumes from its held count; rst_n pulsed mid-BOUNCE -> led=0000 and mode=0 asynchronously.
